// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch
// Program-counter and instruction-fetch front end. Holds the fetch PC, keeps
// at most one instruction-cache request outstanding, and buffers at most one
// fetched instruction (with its PC) for the IF/ID pipeline register. A Branch
// code from the pipeline controller redirects the PC and squashes any
// in-flight or buffered fetch.
//
// Ports
//   clk                  clock, rising edge
//   rst                  asynchronous active-low reset
//   ctrl_signal_pc_i     PC control: 00 run, 01 stall, 10 branch, 11 stall
//   ctrl_to_pc_new_i     redirect target (used only with branch)
//   icache_req_o         fetch request valid
//   icache_addr_o        fetch address (current PC)
//   icache_ready_i       cache accepts the request this cycle
//   icache_data_valid_i  one-cycle response strobe
//   icache_data_i        response instruction
//   if_valid_o           instruction valid to IF/ID
//   if_pc_o              PC of presented instruction
//   if_inst_o            presented instruction (NOP_INST when not valid)
//   if_ready_i           IF/ID accepts the presented instruction
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// REQ   | request presented to the cache, waiting for acceptance
// WAIT  | request accepted, waiting for the response
// KILL  | request squashed by a redirect, waiting to discard its response
// OUT   | instruction buffered and presented to IF/ID
// ---------------------------------------------------------------------------
module pc_fetch #(
    parameter int                 ADDR_W   = 64,
    parameter int                 INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(64'h0000_0000_8000_0000),
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ctrl_signal_pc_i,
    input  logic [ADDR_W-1:0] ctrl_to_pc_new_i,
    output logic              icache_req_o,
    output logic [ADDR_W-1:0] icache_addr_o,
    input  logic              icache_ready_i,
    input  logic              icache_data_valid_i,
    input  logic [INST_W-1:0] icache_data_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    input  logic              if_ready_i
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_KILL = 3'd3,
        ST_OUT  = 3'd4
    } state_e;

    localparam logic [1:0] PC_RUN    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b10;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [INST_W-1:0] if_inst_q, if_inst_d;

    logic is_branch;
    logic is_run;

    assign is_branch = (ctrl_signal_pc_i == PC_BRANCH);
    assign is_run    = (ctrl_signal_pc_i == PC_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= NOP_INST;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                // No request is issued in a redirect cycle; the new target is
                // requested from the following cycle.
                if (is_branch) begin
                    pc_d = ctrl_to_pc_new_i;
                end else if (is_run && icache_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (is_branch) begin
                    pc_d    = ctrl_to_pc_new_i;
                    state_d = icache_data_valid_i ? ST_REQ : ST_KILL;
                end else if (icache_data_valid_i) begin
                    // The cache cannot be held, so a stall still captures.
                    if_inst_d  = icache_data_i;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + ADDR_W'(4);
                    state_d    = ST_OUT;
                end
            end
            ST_KILL: begin
                if (is_branch) begin
                    pc_d = ctrl_to_pc_new_i;
                end
                if (icache_data_valid_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_OUT: begin
                if (is_branch) begin
                    if_valid_d = 1'b0;
                    if_inst_d  = NOP_INST;
                    pc_d       = ctrl_to_pc_new_i;
                    state_d    = ST_REQ;
                end else if (is_run && if_ready_i) begin
                    if_valid_d = 1'b0;
                    if_inst_d  = NOP_INST;
                    state_d    = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign icache_req_o  = (state_q == ST_REQ) && is_run;
    assign icache_addr_o = pc_q;
    assign if_valid_o    = if_valid_q;
    assign if_pc_o       = if_pc_q;
    assign if_inst_o     = if_inst_q;

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch
// Self-checking bench for pc_fetch: reset checks, a directed vector table
// covering straight-line fetch, redirects in every state, stalls and PC
// wrap, an asynchronous mid-operation reset, and a randomized run checked
// against a transaction-level model (outstanding / stale / buffered flags).
// ---------------------------------------------------------------------------
module tb_pc_fetch;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [1:0]  code;
    logic [63:0] target;
    logic        req;
    logic [63:0] addr;
    logic        c_ready;
    logic        c_dv;
    logic [31:0] c_data;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;

    int total;
    int bad;

    pc_fetch dut (
        .clk                 (clk),
        .rst                 (rst),
        .ctrl_signal_pc_i    (code),
        .ctrl_to_pc_new_i    (target),
        .icache_req_o        (req),
        .icache_addr_o       (addr),
        .icache_ready_i      (c_ready),
        .icache_data_valid_i (c_dv),
        .icache_data_i       (c_data),
        .if_valid_o          (if_valid),
        .if_pc_o             (if_pc),
        .if_inst_o           (if_inst),
        .if_ready_i          (if_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  code;
        logic [63:0] target;
        logic        c_ready;
        logic        c_dv;
        logic [31:0] c_data;
        logic        if_ready;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] c, input logic [63:0] t,
                                input logic r, input logic dv,
                                input logic [31:0] d, input logic ifr,
                                input logic er, input logic [63:0] ea,
                                input logic ev, input logic [63:0] ep,
                                input logic [31:0] ei);
        vec_t v;
        v.code = c; v.target = t; v.c_ready = r; v.c_dv = dv; v.c_data = d;
        v.if_ready = ifr; v.e_req = er; v.e_addr = ea; v.e_valid = ev;
        v.e_pc = ep; v.e_inst = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic er, input logic [63:0] ea,
                         input logic ev, input logic [63:0] ep, input logic [31:0] ei);
        total++;
        if (req !== er || addr !== ea || if_valid !== ev || if_pc !== ep || if_inst !== ei) begin
            bad++;
            $display("FAIL %s: got req=%b addr=%h valid=%b pc=%h inst=%h, want req=%b addr=%h valid=%b pc=%h inst=%h",
                     name, req, addr, if_valid, if_pc, if_inst, er, ea, ev, ep, ei);
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic [63:0] t, input logic r,
                         input logic dv, input logic [31:0] d, input logic ifr);
        code = c; target = t; c_ready = r; c_dv = dv; c_data = d; if_ready = ifr;
    endtask

    // Transaction-level reference: tracks whether a request is in flight,
    // whether it has been squashed, and whether an instruction is buffered.
    bit          m_started;
    bit          m_out;
    bit          m_stale;
    bit          m_buf;
    logic [63:0] m_pc;
    logic [63:0] m_ifpc;
    logic [31:0] m_inst;

    task automatic model_reset();
        m_started = 0; m_out = 0; m_stale = 0; m_buf = 0;
        m_pc = RST_PC; m_ifpc = '0; m_inst = NOP;
    endtask

    task automatic model_step(input logic [1:0] c, input logic [63:0] t, input logic r,
                              input logic dv, input logic [31:0] d, input logic ifr);
        bit br;
        bit run;
        br  = (c == 2'b10);
        run = (c == 2'b00);
        if (!m_started) begin
            m_started = 1;
        end else if (m_buf) begin
            if (br) begin
                m_buf = 0;
                m_pc  = t;
            end else if (run && ifr) begin
                m_buf = 0;
            end
        end else if (m_out) begin
            if (dv) begin
                m_out = 0;
                if (!m_stale && !br) begin
                    m_buf  = 1;
                    m_ifpc = m_pc;
                    m_inst = d;
                    m_pc   = m_pc + 64'd4;
                end
                m_stale = 0;
            end else if (br) begin
                m_stale = 1;
            end
            if (br) m_pc = t;
        end else begin
            if (br) m_pc = t;
            else if (run && r) m_out = 1;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(2'b00, '0, 1'b0, 1'b0, '0, 1'b0);

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(2'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom),
                  $urandom, 1'($urandom));
            #1 check("reset_hold", 1'b0, RST_PC, 1'b0, 64'd0, NOP);
        end

        // Directed per-cycle table, starting in the IDLE cycle after release
        vecs.push_back(mk(2'b00, 64'h0,            0, 0, 32'h0,        0, 0, RST_PC,            0, 64'h0,             NOP));
        vecs.push_back(mk(2'b00, 64'h0,            1, 0, 32'h0,        0, 1, RST_PC,            0, 64'h0,             NOP));
        vecs.push_back(mk(2'b00, 64'h0,            0, 1, 32'h00100093, 0, 0, RST_PC,            0, 64'h0,             NOP));
        vecs.push_back(mk(2'b00, 64'h0,            0, 0, 32'h0,        1, 0, 64'h8000_0004,     1, 64'h8000_0000,     32'h00100093));
        vecs.push_back(mk(2'b10, 64'h8000_1000,    1, 0, 32'h0,        0, 0, 64'h8000_0004,     0, 64'h8000_0000,     NOP));
        vecs.push_back(mk(2'b00, 64'h0,            1, 0, 32'h0,        0, 1, 64'h8000_1000,     0, 64'h8000_0000,     NOP));
        vecs.push_back(mk(2'b10, 64'h8000_2000,    0, 0, 32'h0,        0, 0, 64'h8000_1000,     0, 64'h8000_0000,     NOP));
        vecs.push_back(mk(2'b10, 64'h8000_3000,    0, 0, 32'h0,        0, 0, 64'h8000_2000,     0, 64'h8000_0000,     NOP));
        vecs.push_back(mk(2'b00, 64'h0,            0, 1, 32'hDEADBEEF, 1, 0, 64'h8000_3000,     0, 64'h8000_0000,     NOP));
        vecs.push_back(mk(2'b00, 64'h0,            0, 0, 32'h0,        1, 1, 64'h8000_3000,     0, 64'h8000_0000,     NOP));
        vecs.push_back(mk(2'b01, 64'h0,            1, 0, 32'h0,        1, 0, 64'h8000_3000,     0, 64'h8000_0000,     NOP));
        vecs.push_back(mk(2'b00, 64'h0,            1, 0, 32'h0,        1, 1, 64'h8000_3000,     0, 64'h8000_0000,     NOP));
        vecs.push_back(mk(2'b10, 64'h8000_1000,    0, 1, 32'h11111111, 1, 0, 64'h8000_3000,     0, 64'h8000_0000,     NOP));
        vecs.push_back(mk(2'b00, 64'h0,            1, 0, 32'h0,        0, 1, 64'h8000_1000,     0, 64'h8000_0000,     NOP));
        vecs.push_back(mk(2'b01, 64'h0,            0, 1, 32'h00200113, 0, 0, 64'h8000_1000,     0, 64'h8000_0000,     NOP));
        vecs.push_back(mk(2'b00, 64'h0,            0, 0, 32'h0,        0, 0, 64'h8000_1004,     1, 64'h8000_1000,     32'h00200113));
        vecs.push_back(mk(2'b01, 64'h0,            0, 0, 32'h0,        1, 0, 64'h8000_1004,     1, 64'h8000_1000,     32'h00200113));
        vecs.push_back(mk(2'b11, 64'h0,            0, 0, 32'h0,        1, 0, 64'h8000_1004,     1, 64'h8000_1000,     32'h00200113));
        vecs.push_back(mk(2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 32'h0, 0, 0, 64'h8000_1004,     1, 64'h8000_1000,     32'h00200113));
        vecs.push_back(mk(2'b00, 64'h0,            1, 0, 32'h0,        0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h8000_1000, NOP));
        vecs.push_back(mk(2'b00, 64'h0,            0, 1, 32'h00300193, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h8000_1000, NOP));
        vecs.push_back(mk(2'b00, 64'h0,            0, 0, 32'h0,        1, 0, 64'h0,             1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h00300193));
        vecs.push_back(mk(2'b00, 64'h0,            0, 0, 32'h0,        0, 1, 64'h0,             0, 64'hFFFF_FFFF_FFFF_FFFC, NOP));

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i].code, vecs[i].target, vecs[i].c_ready, vecs[i].c_dv,
                  vecs[i].c_data, vecs[i].if_ready);
            #1 check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                     vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_inst);
        end

        // Accept a request, then reset asynchronously while it is in flight
        @(negedge clk);
        drive(2'b00, '0, 1'b1, 1'b0, '0, 1'b0);
        #1 check("pre_midreset_req", 1'b1, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, NOP);
        @(posedge clk);
        #2 rst = 1'b0;
        c_dv = 1'b1;
        #1 check("midreset", 1'b0, RST_PC, 1'b0, 64'd0, NOP);

        // Randomized run against the model; a stray response right after
        // release must be ignored.
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  c;
            logic [63:0] t;
            logic        r, dv, ifr;
            logic [31:0] d;
            int          sel;
            if (i > 0) @(negedge clk);
            sel = int'($urandom_range(0, 9));
            c   = (sel < 6) ? 2'b00 : (sel < 8) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            t   = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
            r   = 1'($urandom_range(0, 2) != 0);
            ifr = 1'($urandom_range(0, 2) != 0);
            d   = $urandom;
            dv  = m_out ? 1'($urandom_range(0, 2) == 0) : (i < 2);
            drive(c, t, r, dv, d, ifr);
            #1 check("random", m_started && !m_out && !m_buf && (c == 2'b00),
                     m_pc, m_buf, m_ifpc, m_buf ? m_inst : NOP);
            @(posedge clk);
            model_step(c, t, r, dv, d, ifr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
